cmem_seq: RTL and testbench

//  Control stage directly upstream of the 8-bank coefficient memory (cmem) in the FIR core.
//  - Loads a coefficient stream into the banks through cmem's write port.
//  - Per input sample, issues one read pass that presents NBANK taps per cycle on the

---
 rtl/cmem_seq.sv | 154 +++++++++++++++
 tb/tb_cmem_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_seq.sv
// Sequencer in front of the 8-bank coefficient memory: interleaved coefficient load,
// per-sample parallel read passes, and MAC strobes aligned to cmem read latency.

module cmem_seq_lane #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] nxt,
  output logic [AW-1:0] addr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  addr <= '0;
    else if (en) addr <= nxt;
endmodule

module cmem_seq #(
  parameter int NBANK = 8,
  parameter int TAPS  = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DW-1:0]       cfg_data,
  input  logic                cfg_last,
  input  logic                run_en,
  input  logic                samp_valid,
  output logic [DW-1:0]       cmem_d,
  output logic [10:0]         cmem_caddr,
  output logic                cmem_wen,
  output logic                cmem_cen,
  output logic [NBANK*AW-1:0] cmem_raddr,
  output logic                mac_en,
  output logic                mac_first,
  output logic                mac_last,
  output logic                busy,
  output logic                load_err,
  output logic                overrun
);
  localparam int CAP    = NBANK * TAPS;
  localparam int KW     = $clog2(CAP) + 1;
  localparam int BW     = $clog2(NBANK);
  localparam int STAGES = 2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_DRAIN, S_READY, S_PASS} state_t;

  state_t                    state, state_nxt;
  logic [KW-1:0]             k;
  logic [AW-1:0]             j, j_nxt;
  logic                      accept, last_k, wr_now, load_clr, err_set, ovr_set;
  logic                      pass_vld, pass_final, pass_go, j_en;
  logic [DW-1:0]             wr_data;
  logic [10:0]               wr_addr, pend_addr;
  logic                      wr_pend;
  logic [STAGES:1]           vld_pipe, first_pipe, last_pipe;
  logic [NBANK-1:0][AW-1:0]  raddr_lane;

  assign cfg_ready  = (state == S_LOAD) || (state == S_DRAIN);
  assign busy       = (state != S_IDLE) && (state != S_READY);
  assign cmem_cen   = (state == S_IDLE);
  assign accept     = cfg_valid & cfg_ready;
  assign last_k     = (k == KW'(CAP - 1));
  assign load_clr   = load_start & ((state == S_IDLE) || (state == S_READY));
  assign pass_vld   = (state == S_PASS);
  assign pass_final = pass_vld && (j == AW'(TAPS - 1));
  assign pass_go    = samp_valid & run_en & ~load_clr & ((state == S_READY) | pass_final);
  assign j_en       = pass_go | (pass_vld & ~pass_final);
  assign j_nxt      = pass_go ? '0 : j + AW'(1);
  assign wr_now     = ((state == S_LOAD) & accept) | (state == S_FILL);
  assign wr_data    = (state == S_LOAD) ? cfg_data : '0;
  // interleave: bank = k % NBANK, word = k / NBANK
  assign wr_addr    = {3'(k[BW-1:0]), 8'(k >> BW)};
  assign err_set    = (state == S_LOAD) & accept & last_k & ~cfg_last;
  assign ovr_set    = pass_vld & samp_valid & ~pass_final;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load_start) state_nxt = S_LOAD;
      S_LOAD:  if (accept) begin
                 if (last_k)        state_nxt = cfg_last ? S_READY : S_DRAIN;
                 else if (cfg_last) state_nxt = S_FILL;
               end
      S_FILL:  if (last_k) state_nxt = S_READY;
      S_DRAIN: if (accept && cfg_last) state_nxt = S_READY;
      S_READY: if (load_start)   state_nxt = S_LOAD;
               else if (pass_go) state_nxt = S_PASS;
      S_PASS:  if (pass_final && !pass_go) state_nxt = S_READY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // cmem latches D on the edge but decodes CADDR/WEN combinationally, so the
  // strobe trails the data by one register stage.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k          <= '0;
      cmem_d     <= '0;
      pend_addr  <= '0;
      wr_pend    <= 1'b0;
      cmem_caddr <= '0;
      cmem_wen   <= 1'b1;
      j          <= '0;
      load_err   <= 1'b0;
      overrun    <= 1'b0;
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      if (load_clr)    k <= '0;
      else if (wr_now) k <= k + KW'(1);
      if (wr_now) begin
        cmem_d    <= wr_data;
        pend_addr <= wr_addr;
      end
      wr_pend  <= wr_now;
      cmem_wen <= ~wr_pend;
      if (wr_pend) cmem_caddr <= pend_addr;
      if (j_en) j <= j_nxt;
      if (load_clr)     load_err <= 1'b0;
      else if (err_set) load_err <= 1'b1;
      if (load_clr)     overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
      vld_pipe   <= {vld_pipe[STAGES-1:1], pass_vld};
      first_pipe <= {first_pipe[STAGES-1:1], pass_vld && (j == '0)};
      last_pipe  <= {last_pipe[STAGES-1:1], pass_final};
    end

  assign mac_en    = vld_pipe[STAGES];
  assign mac_first = first_pipe[STAGES];
  assign mac_last  = last_pipe[STAGES];

  // one address register per bank keeps read-address fanout local to each bank
  for (genvar b = 0; b < NBANK; b++) begin : g_lane
    cmem_seq_lane #(.AW(AW)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (j_en),
      .nxt  (j_nxt),
      .addr (raddr_lane[b])
    );
  end

  assign cmem_raddr = raddr_lane;
endmodule

// File: tb/tb_cmem_seq.sv
// Directed bench for cmem_seq with a behavioural cmem write port (D registered, CADDR/WEN live).
module tb_cmem_seq;
  localparam int NBANK = 8, TAPS = 64, AW = 6, DW = 16, CAP = 512;

  logic clk = 1'b0, rst_n;
  logic load_start, cfg_valid, cfg_last, run_en, samp_valid;
  logic [DW-1:0] cfg_data;
  logic cfg_ready, cmem_wen, cmem_cen, mac_en, mac_first, mac_last, busy, load_err, overrun;
  logic [DW-1:0] cmem_d;
  logic [10:0] cmem_caddr;
  logic [NBANK*AW-1:0] cmem_raddr;

  always #5 clk = ~clk;

  cmem_seq #(.NBANK(NBANK), .TAPS(TAPS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last), .run_en(run_en),
    .samp_valid(samp_valid), .cmem_d(cmem_d), .cmem_caddr(cmem_caddr), .cmem_wen(cmem_wen),
    .cmem_cen(cmem_cen), .cmem_raddr(cmem_raddr), .mac_en(mac_en), .mac_first(mac_first),
    .mac_last(mac_last), .busy(busy), .load_err(load_err), .overrun(overrun)
  );

  int vectors = 0, miscompares = 0;

  logic [DW-1:0] mem [0:2047];
  logic [DW-1:0] dq;
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (cmem_wen === 1'b0) begin
      mem[cmem_caddr] = dq;
      wr_cnt++;
    end
    dq = cmem_d;
  end

  logic se [0:199], sf [0:199], sl [0:199], sb [0:199];
  logic [NBANK*AW-1:0] sr [0:199];

  function automatic logic [10:0] ca(input int k);
    logic [31:0] kk;
    kk = k;
    return {kk[2:0], kk[10:3]};
  endfunction

  function automatic logic [NBANK*AW-1:0] rep(input int j);
    logic [AW-1:0] a;
    a = AW'(j);
    return {NBANK{a}};
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  // sample index s = cycle s; samp_valid driven at indices pa/pb
  task automatic run_seq(input int n, input int pa, input int pb, input logic re);
    for (int s = 0; s < n; s++) begin
      se[s] = mac_en; sf[s] = mac_first; sl[s] = mac_last; sb[s] = busy; sr[s] = cmem_raddr;
      samp_valid = (s == pa) || (s == pb);
      run_en = re;
      step;
    end
    samp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load_start = 0; cfg_valid = 0; cfg_last = 0; cfg_data = '0;
    run_en = 0; samp_valid = 0;
    repeat (3) step;
    #2 rst_n = 1'b1;
    step;
    vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_ready: got %b exp 0", cfg_ready); end
    vectors++; if (cmem_wen !== 1'b1) begin miscompares++; $display("FAIL reset_wen: got %b exp 1", cmem_wen); end
    vectors++; if (cmem_cen !== 1'b1) begin miscompares++; $display("FAIL reset_cen: got %b exp 1", cmem_cen); end
    vectors++; if (cmem_d !== '0) begin miscompares++; $display("FAIL reset_d: got %h exp 0", cmem_d); end
    vectors++; if (cmem_caddr !== '0) begin miscompares++; $display("FAIL reset_caddr: got %h exp 0", cmem_caddr); end
    vectors++; if (cmem_raddr !== '0) begin miscompares++; $display("FAIL reset_raddr: got %h exp 0", cmem_raddr); end
    vectors++; if ({mac_en, mac_first, mac_last} !== 3'b000) begin miscompares++; $display("FAIL reset_mac: got %b exp 000", {mac_en, mac_first, mac_last}); end
    vectors++; if ({busy, load_err, overrun} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b exp 000", {busy, load_err, overrun}); end
  endtask

  task automatic test_full_load;
    int bad, w0;
    load_start = 1; step; load_start = 0;
    vectors++; if ({busy, cfg_ready} !== 2'b11) begin miscompares++; $display("FAIL full_enter_load: got %b exp 11", {busy, cfg_ready}); end
    w0 = wr_cnt;
    for (int k = 0; k < CAP; k++) begin
      cfg_valid = 1; cfg_data = DW'(k); cfg_last = (k == CAP - 1); load_start = (k == 300);
      step;
    end
    cfg_valid = 0; cfg_last = 0; load_start = 0;
    vectors++; if ({busy, cmem_cen} !== 2'b00) begin miscompares++; $display("FAIL full_ready: got %b exp 00", {busy, cmem_cen}); end
    repeat (3) step;
    vectors++; if (wr_cnt - w0 !== 512) begin miscompares++; $display("FAIL full_writes: got %0d exp 512", wr_cnt - w0); end
    vectors++; if (mem[11'h101] !== 16'd9) begin miscompares++; $display("FAIL full_word9: got %h exp 0009", mem[11'h101]); end
    bad = 0;
    for (int k = 0; k < CAP; k++) if (mem[ca(k)] !== DW'(k)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL full_contents: got %0d bad words exp 0", bad); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL full_load_err: got %b exp 0", load_err); end
    vectors++; if (cmem_caddr !== 11'h73F) begin miscompares++; $display("FAIL full_caddr_hold: got %h exp 73f", cmem_caddr); end
  endtask

  task automatic test_pass;
    int bad;
    run_seq(4, 0, -1, 1'b0);
    bad = 0;
    for (int s = 0; s < 4; s++) if (sb[s] !== 1'b0) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pass_run_en_off: got %0d busy cycles exp 0", bad); end
    run_seq(70, 0, -1, 1'b1);
    bad = 0;
    for (int s = 1; s <= 64; s++) if (sr[s] !== rep(s - 1)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pass_raddr: got %0d bad cycles exp 0", bad); end
    bad = 0;
    for (int s = 0; s < 70; s++) if (se[s] !== (s >= 3 && s <= 66)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pass_mac_en: got %0d bad cycles exp 0", bad); end
    bad = 0;
    for (int s = 0; s < 70; s++) if (sf[s] !== (s == 3) || sl[s] !== (s == 66)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pass_first_last: got %0d bad cycles exp 0", bad); end
    bad = 0;
    for (int s = 0; s < 70; s++) if (sb[s] !== (s >= 1 && s <= 64)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pass_busy: got %0d bad cycles exp 0", bad); end
    vectors++; if (sr[69] !== rep(63)) begin miscompares++; $display("FAIL pass_raddr_hold: got %h exp %h", sr[69], rep(63)); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL pass_overrun: got %b exp 0", overrun); end
  endtask

  task automatic test_back_to_back;
    int bad;
    run_seq(140, 0, 64, 1'b1);
    bad = 0;
    for (int s = 1; s <= 128; s++) if (sr[s] !== rep((s - 1) % 64)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_raddr: got %0d bad cycles exp 0", bad); end
    bad = 0;
    for (int s = 0; s < 140; s++) if (se[s] !== (s >= 3 && s <= 130)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_mac_en: got %0d bad cycles exp 0", bad); end
    bad = 0;
    for (int s = 0; s < 140; s++) if (sf[s] !== (s == 3 || s == 67) || sl[s] !== (s == 66 || s == 130)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_first_last: got %0d bad cycles exp 0", bad); end
    vectors++; if ({sb[65], sb[129]} !== 2'b10) begin miscompares++; $display("FAIL b2b_busy: got %b exp 10", {sb[65], sb[129]}); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_no_overrun: got %b exp 0", overrun); end
  endtask

  task automatic test_overrun;
    int cnt;
    run_seq(70, 0, 11, 1'b1);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
    cnt = 0;
    for (int s = 0; s < 70; s++) if (se[s] === 1'b1) cnt++;
    vectors++; if (cnt !== 64) begin miscompares++; $display("FAIL ovr_pass_len: got %0d exp 64", cnt); end
    vectors++; if ({sr[12], sb[65]} !== {rep(11), 1'b0}) begin miscompares++; $display("FAIL ovr_continue: got %h exp %h", {sr[12], sb[65]}, {rep(11), 1'b0}); end
  endtask

  task automatic test_short_load;
    int bad, w0, cyc, rdy;
    load_start = 1; step; load_start = 0;
    vectors++; if ({overrun, load_err} !== 2'b00) begin miscompares++; $display("FAIL short_flags_clear: got %b exp 00", {overrun, load_err}); end
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1; cfg_data = 16'hA000 + DW'(k); cfg_last = (k == 2);
      step;
    end
    cfg_valid = 0; cfg_last = 0;
    vectors++; if ({busy, cfg_ready} !== 2'b10) begin miscompares++; $display("FAIL short_fill_enter: got %b exp 10", {busy, cfg_ready}); end
    cyc = 0; rdy = 0;
    while (busy === 1'b1 && cyc < 600) begin
      if (cfg_ready !== 1'b0) rdy++;
      cyc++; step;
    end
    vectors++; if (cyc !== 509) begin miscompares++; $display("FAIL short_fill_cycles: got %0d exp 509", cyc); end
    vectors++; if (rdy !== 0) begin miscompares++; $display("FAIL short_fill_ready: got %0d ready cycles exp 0", rdy); end
    repeat (3) step;
    vectors++; if (wr_cnt - w0 !== 512) begin miscompares++; $display("FAIL short_writes: got %0d exp 512", wr_cnt - w0); end
    bad = 0;
    for (int k = 0; k < CAP; k++) if (mem[ca(k)] !== ((k < 3) ? 16'hA000 + DW'(k) : 16'h0)) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL short_contents: got %0d bad words exp 0", bad); end
  endtask

  task automatic test_overflow;
    int bad, w0;
    logic le512, rd512;
    le512 = 0; rd512 = 0;
    load_start = 1; step; load_start = 0;
    w0 = wr_cnt;
    for (int k = 0; k < 515; k++) begin
      if (k == 512) begin le512 = load_err; rd512 = cfg_ready; end
      cfg_valid = 1; cfg_data = 16'h8000 | DW'(k); cfg_last = (k == 514);
      step;
    end
    cfg_valid = 0; cfg_last = 0;
    vectors++; if ({le512, rd512} !== 2'b11) begin miscompares++; $display("FAIL ovf_drain: got %b exp 11", {le512, rd512}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_ready: got busy %b exp 0", busy); end
    repeat (3) step;
    vectors++; if (wr_cnt - w0 !== 512) begin miscompares++; $display("FAIL ovf_writes: got %0d exp 512", wr_cnt - w0); end
    bad = 0;
    for (int k = 0; k < CAP; k++) if (mem[ca(k)] !== (16'h8000 | DW'(k))) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ovf_contents: got %0d bad words exp 0", bad); end
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL ovf_load_err: got %b exp 1", load_err); end
  endtask

  task automatic test_reset_mid_load;
    load_start = 1; step; load_start = 0;
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL midload_err_clear: got %b exp 0", load_err); end
    for (int k = 0; k < 100; k++) begin
      cfg_valid = 1; cfg_data = DW'(k); step;
    end
    rst_n = 1'b0; #1;
    vectors++; if ({cfg_ready, busy, cmem_cen, cmem_wen} !== 4'b0011) begin miscompares++; $display("FAIL midload_reset: got %b exp 0011", {cfg_ready, busy, cmem_cen, cmem_wen}); end
    vectors++; if ({cmem_caddr, cmem_d} !== '0) begin miscompares++; $display("FAIL midload_regs: got %h exp 0", {cmem_caddr, cmem_d}); end
    cfg_valid = 0;
    #2 rst_n = 1'b1;
    step;
    vectors++; if ({cfg_ready, busy} !== 2'b00) begin miscompares++; $display("FAIL midload_idle: got %b exp 00", {cfg_ready, busy}); end
  endtask

  task automatic test_reset_mid_pass;
    test_full_load;
    run_seq(21, 0, -1, 1'b1);
    vectors++; if ({cmem_raddr, mac_en} !== {rep(20), 1'b1}) begin miscompares++; $display("FAIL midpass_pre: got %h exp %h", {cmem_raddr, mac_en}, {rep(20), 1'b1}); end
    rst_n = 1'b0; #1;
    vectors++; if ({mac_en, mac_first, mac_last, cmem_cen, busy} !== 5'b00010) begin miscompares++; $display("FAIL midpass_reset: got %b exp 00010", {mac_en, mac_first, mac_last, cmem_cen, busy}); end
    vectors++; if (cmem_raddr !== '0) begin miscompares++; $display("FAIL midpass_raddr: got %h exp 0", cmem_raddr); end
    #2 rst_n = 1'b1;
    step;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    test_reset;
    test_full_load;
    test_pass;
    test_back_to_back;
    test_overrun;
    test_short_load;
    test_overflow;
    test_reset_mid_load;
    test_reset_mid_pass;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
